i2s_tx: RTL and testbench

I2S transmitter for the audio output path (DAC or class-D amplifier): the companion to the microphone receiver. It accepts one stereo sample pair per frame over a valid/ready handshake and buffers it in a one-frame holding register. It then serialises the pair MSB-first onto SDATA, generating its own BCLK and LRCLK from the single system clock. Missing samples produce silence and an underrun pulse.

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_clk_div.sv | 40 ++++
 rtl/i2s_tx.sv | 148 ++++++++++++++
 tb/tb_i2s_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM state type, default geometry and a parameter
// legality check used at elaboration by the transmitter and receiver.
package i2s_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } i2s_state_t;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_SLOT    = 32;
  localparam int unsigned DEF_CLK_DIV = 4;

  // Left-justified framing may fill the whole slot; standard I2S loses one
  // BCLK to the MSB delay, so the sample must be strictly narrower than SLOT.
  function automatic bit i2s_params_ok(input int unsigned width,
                                       input int unsigned slot,
                                       input int unsigned clk_div,
                                       input bit          lj);
    bit fit;
    fit = lj ? (width <= slot) : (width < slot);
    return (width >= 1) && fit && (clk_div >= 2) && ((clk_div % 2) == 0);
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK divider: owns div_cnt, drives a registered bclk and flags the clk
// cycle on whose closing edge bclk falls (fall_stb) or rises (rise_stb).
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);

  logic [DW-1:0] div_cnt;

  assign fall_stb = en && (div_cnt == DIV_LAST);
  assign rise_stb = en && (div_cnt == DIV_HALF);

  // Free-running divider while enabled; parked at zero with bclk low otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= fall_stb ? '0 : div_cnt + 1'b1;
      if (rise_stb) begin
        bclk <= 1'b1;
      end else if (fall_stb) begin
        bclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-frame holding register behind a valid/ready port,
// serialised MSB-first on sdata with locally generated bclk/lrclk.
// Define I2S_TX_LJ_EN for left-justified framing (MSB at slot position 0);
// otherwise standard I2S with the MSB one BCLK after the lrclk edge.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SLOT    = DEF_SLOT,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             frame_start,
  output logic             underrun
);

`ifdef I2S_TX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  localparam int unsigned BW = $clog2(2 * SLOT);
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
  localparam logic [BW-1:0] P_LO     = LJ ? '0 : BW'(1);
  localparam logic [BW-1:0] WIDTH_B  = BW'(WIDTH);

  if (!i2s_params_ok(WIDTH, SLOT, CLK_DIV, LJ)) begin : g_bad_params
    $error("i2s_tx: illegal WIDTH/SLOT/CLK_DIV combination");
  end

  i2s_state_t       state;
  logic [BW-1:0]    bit_cnt;
  logic             hold_full;
  logic [WIDTH-1:0] hold_l, hold_r;
  logic [WIDTH-1:0] sh_l, sh_r;

  logic             fall_stb;
  logic             accept;
  logic             step;
  logic             load;
  logic [BW-1:0]    bit_cnt_n;
  logic [BW-1:0]    p_n;
  logic             chan_n;
  logic             in_win;
  logic             sdata_n;
  logic [WIDTH-1:0] new_l, new_r;
  logic [WIDTH-1:0] sh_l_n, sh_r_n;

  assign s_ready = !hold_full;
  assign accept  = s_valid && s_ready;

  i2s_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == RUN),
    .bclk     (bclk),
    .fall_stb (fall_stb),
    .rise_stb ()
  );

  // Next bit position and serialiser contents for the upcoming bclk low phase.
  // Leaving IDLE is treated as a fall strobe onto bit 0 so the first frame
  // loads through the same path as every later one.
  always_comb begin
    step      = 1'b0;
    bit_cnt_n = bit_cnt;
    if (state == IDLE) begin
      step      = hold_full;
      bit_cnt_n = '0;
    end else begin
      step      = fall_stb;
      bit_cnt_n = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
    load   = step && (bit_cnt_n == '0);
    chan_n = (bit_cnt_n >= SLOT_B);
    p_n    = chan_n ? bit_cnt_n - SLOT_B : bit_cnt_n;
    // Unsigned wrap makes positions before P_LO fall outside the window.
    in_win = (BW'(p_n - P_LO) < WIDTH_B);
    new_l  = load ? (hold_full ? hold_l : '0) : sh_l;
    new_r  = load ? (hold_full ? hold_r : '0) : sh_r;
    sh_l_n  = new_l;
    sh_r_n  = new_r;
    sdata_n = 1'b0;
    if (in_win) begin
      if (chan_n) begin
        sdata_n = new_r[WIDTH-1];
        sh_r_n  = new_r << 1;
      end else begin
        sdata_n = new_l[WIDTH-1];
        sh_l_n  = new_l << 1;
      end
    end
  end

  // Control FSM with holding register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      // An accept can only coincide with a load that found the register empty,
      // so the new pair survives the load and plays in the following frame.
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_l    <= s_left;
        hold_r    <= s_right;
      end
      if (step) begin
        state   <= RUN;
        bit_cnt <= bit_cnt_n;
        lrclk   <= chan_n;
        sdata   <= sdata_n;
        sh_l    <= sh_l_n;
        sh_r    <= sh_r_n;
        if (load) begin
          frame_start <= 1'b1;
          underrun    <= !hold_full;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: directed frame sequence with random sample
// data and push timing, compared cycle by cycle with a frame-level model.
module tb_i2s_tx;

`ifdef I2S_TX_LJ_EN
  localparam int W  = 16;
  localparam int S  = 16;
  localparam int P0 = 0;
`else
  localparam int W  = 16;
  localparam int S  = 32;
  localparam int P0 = 1;
`endif
  localparam int D       = 4;
  localparam int FC      = 2 * S * D;
  localparam int ABORT_C = (40 % (2 * S)) * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_left = '0;
  logic [W-1:0] s_right = '0;
  logic         bclk, lrclk, sdata, frame_start, underrun;

  always #5 clk = ~clk;

  i2s_tx #(
    .WIDTH   (W),
    .SLOT    (S),
    .CLK_DIV (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int checks = 0;
  int errors = 0;
  int cur_c  = 0;

  // Model state: holding register contents and the pair playing this frame.
  bit           hold_full = 1'b0;
  logic [W-1:0] hold_l = '0, hold_r = '0;
  logic [W-1:0] play_l = '0, play_r = '0;
  bit           play_under = 1'b0;
  logic [W-1:0] cand_l = '0, cand_r = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c=%0d obs=%0h exp=%0h", tag, cur_c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_cand();
    cand_l = W'($urandom);
    cand_r = W'($urandom);
  endtask

  // Expected sdata at clk offset c of a frame carrying samples l/r.
  function automatic logic exp_sdata(input logic [W-1:0] l, input logic [W-1:0] r, input int c);
    int k;
    int p;
    logic [W-1:0] smp;
    k   = c / D;
    p   = k % S;
    smp = (k >= S) ? r : l;
    if (p >= P0 && p < P0 + W) return smp[W-1-(p-P0)];
    return 1'b0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b0);
    chk({tag, "_lrclk"}, lrclk, 1'b0);
    chk({tag, "_sdata"}, sdata, 1'b0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ur"}, underrun, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b1);
  endtask

  // One frame from its first cycle; optional offer at push_at or all frame
  // long (keep_valid); abort_at stops before driving that cycle.
  task automatic run_frame(input int push_at, input bit keep_valid, input int abort_at);
    int           accepts;
    int           model_acc;
    bit           acc;
    bit           ld_full;
    logic [W-1:0] ld_l, ld_r;
    accepts   = 0;
    model_acc = 0;
    for (int c = 0; c < FC; c++) begin
      cur_c = c;
      chk("bclk", bclk, (c % D) >= D / 2);
      chk("lrclk", lrclk, c >= FC / 2);
      chk("sdata", sdata, exp_sdata(play_l, play_r, c));
      chk("frame_start", frame_start, c == 0);
      chk("underrun", underrun, (c == 0) && play_under);
      chk("s_ready", s_ready, !hold_full);
      if (c == abort_at) return;
      s_valid = keep_valid || (c == push_at);
      s_left  = cand_l;
      s_right = cand_r;
      acc = s_valid && !hold_full;
      if (s_valid && s_ready) accepts++;
      if (acc) model_acc++;
      ld_full = hold_full;
      ld_l    = hold_l;
      ld_r    = hold_r;
      tick();
      s_valid = 1'b0;
      if (c == FC - 1) begin
        play_under = !ld_full;
        play_l     = ld_full ? ld_l : '0;
        play_r     = ld_full ? ld_r : '0;
        hold_full  = 1'b0;
      end
      if (acc) begin
        hold_full = 1'b1;
        hold_l    = cand_l;
        hold_r    = cand_r;
        new_cand();
      end
    end
    chk("accepts", accepts, model_acc);
    if (keep_valid) chk("accepts_cont", accepts, 1);
  endtask

  task automatic start_from_idle(input logic [W-1:0] l, input logic [W-1:0] r);
    cur_c   = -1;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    chk("idle_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("ready_after_acc", s_ready, 1'b0);
    chk("idle_fs", frame_start, 1'b0);
    chk("idle_bclk_acc", bclk, 1'b0);
    tick();
    play_l     = l;
    play_r     = r;
    play_under = 1'b0;
    hold_full  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] first_l;
    new_cand();
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_bclk", bclk, 1'b0);
      chk("idle_lrclk", lrclk, 1'b0);
      chk("idle_fs0", frame_start, 1'b0);
    end

`ifdef I2S_TX_LJ_EN
    first_l = '1;
`else
    first_l = W'(16'h8001);
`endif
    start_from_idle(first_l, W'(16'h7FFE));
    run_frame(-1, 1'b0, -1);                            // directed pair, then starve
    run_frame($urandom_range(1, FC - 2), 1'b0, -1);     // underrun frame, refill
    repeat (4) run_frame(-1, 1'b1, -1);                 // continuous feed
    run_frame(-1, 1'b0, -1);                            // last fed pair, no refill
    run_frame(FC - 1, 1'b0, -1);                        // underrun, offer on load cycle
    run_frame(-1, 1'b0, -1);                            // underrun with register full
    run_frame($urandom_range(1, FC - 2), 1'b0, -1);     // late pair plays, refill
    run_frame(-1, 1'b0, ABORT_C);                       // abort mid-frame

    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst_n     = 1'b1;
    hold_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_bclk", bclk, 1'b0);
      chk("post_rst_fs", frame_start, 1'b0);
      chk("post_rst_ready", s_ready, 1'b1);
    end
    start_from_idle(W'($urandom), W'($urandom));
    run_frame(-1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
